// File: rtl/dcache_pkg.sv
// Tag store layout and tag-controller request opcodes.
package dcache_pkg;

    typedef enum logic [1:0] {
        DCACHE_TAG_LOOKUP = 2'd0,
        DCACHE_TAG_FILL   = 2'd1,
        DCACHE_TAG_INVAL  = 2'd2,
        DCACHE_TAG_NOP    = 2'd3
    } dcache_tag_op_t;

    localparam int unsigned DCACHE_TAG_WIDTH             = 20;
    localparam int unsigned DCACHE_TAG_STORE_DATA_WIDTH  = 32;
    // Valid bit sits alone in the top byte so an invalidate can clear it
    // with a single byte-enable and leave the stored tag intact.
    localparam int unsigned TAG_STORE_VALID_BIT_POSITION = 31;

endpackage

// File: rtl/wt_cache_pkg.sv
// Write-through cache geometry shared by the dcache blocks.
package wt_cache_pkg;

    localparam int unsigned DCACHE_NUM_WORDS = 256;

endpackage

// File: rtl/dcache_tag_ctrl.sv
// Requester-side controller for the dcache tag store SRAM: clears every
// entry after reset and on flush, then serves lookup/fill/invalidate.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | post-reset clear sweep, one entry per cycle, no requests
// ST_IDLE  | serving requests, one per cycle
// ST_FLUSH | flush clear sweep, flush_done_o pulses when it finishes
module dcache_tag_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = dcache_pkg::DCACHE_TAG_STORE_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = dcache_pkg::DCACHE_TAG_WIDTH,
    parameter int unsigned NUM_WORDS  = wt_cache_pkg::DCACHE_NUM_WORDS
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    output logic                         busy_o,
    output logic                         flush_done_o,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [1:0]                   req_op_i,
    input  logic [$clog2(NUM_WORDS)-1:0] req_index_i,
    input  logic [TAG_WIDTH-1:0]         req_tag_i,
    output logic                         rsp_valid_o,
    output logic                         rsp_hit_o,
    output logic [TAG_WIDTH-1:0]         rsp_tag_o,
    output logic                         ts_en_o,
    output logic                         ts_we_o,
    output logic [DATA_WIDTH/8-1:0]      ts_be_o,
    output logic [$clog2(NUM_WORDS)-1:0] ts_addr_o,
    output logic [DATA_WIDTH-1:0]        ts_wdata_o,
    input  logic [DATA_WIDTH-1:0]        ts_rdata_i
);

    localparam int unsigned AW  = $clog2(NUM_WORDS);
    localparam int unsigned VBP = TAG_STORE_VALID_BIT_POSITION;
    localparam int unsigned VB  = VBP / 8;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic                 lookup_q, lookup_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic                 flush_done_q, flush_done_d;

    dcache_tag_op_t op;
    assign op = dcache_tag_op_t'(req_op_i);

    // Sweep sequencing, request decode and SRAM port drive.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lookup_d     = 1'b0;
        tag_d        = tag_q;
        flush_done_d = 1'b0;
        busy_o       = 1'b0;
        req_ready_o  = 1'b0;
        ts_en_o      = 1'b0;
        ts_we_o      = 1'b0;
        ts_be_o      = '0;
        ts_addr_o    = req_index_i;
        ts_wdata_o   = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = !flush_i;
                if (flush_i) begin
                    // Flush wins over a request presented in the same cycle.
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else if (req_valid_i) begin
                    case (op)
                        DCACHE_TAG_LOOKUP: begin
                            ts_en_o  = 1'b1;
                            lookup_d = 1'b1;
                            tag_d    = req_tag_i;
                        end
                        DCACHE_TAG_FILL: begin
                            ts_en_o                   = 1'b1;
                            ts_we_o                   = 1'b1;
                            ts_be_o                   = '1;
                            ts_wdata_o[TAG_WIDTH-1:0] = req_tag_i;
                            ts_wdata_o[VBP]           = 1'b1;
                        end
                        DCACHE_TAG_INVAL: begin
                            ts_en_o     = 1'b1;
                            ts_we_o     = 1'b1;
                            ts_be_o[VB] = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                // INIT and FLUSH share the clearing sweep; flush_i is ignored.
                busy_o    = 1'b1;
                ts_en_o   = 1'b1;
                ts_we_o   = 1'b1;
                ts_be_o   = '1;
                ts_addr_o = cnt_q;
                if (cnt_q == AW'(NUM_WORDS - 1)) begin
                    cnt_d        = '0;
                    state_d      = ST_IDLE;
                    flush_done_d = (state_q == ST_FLUSH);
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
        endcase
    end

    // Lookup response, built from the read data the cycle after acceptance.
    always_comb begin
        rsp_valid_o = lookup_q;
        rsp_tag_o   = ts_rdata_i[TAG_WIDTH-1:0];
        rsp_hit_o   = lookup_q && ts_rdata_i[VBP]
                      && (ts_rdata_i[TAG_WIDTH-1:0] == tag_q);
    end

    assign flush_done_o = flush_done_q;

    // Read data bits between the tag and the valid bit carry no meaning.
    logic unused_rdata;
    assign unused_rdata = ^ts_rdata_i;

    // State registers; reset restarts the clearing sweep at index 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            lookup_q     <= 1'b0;
            tag_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lookup_q     <= lookup_d;
            tag_q        <= tag_d;
            flush_done_q <= flush_done_d;
        end
    end

endmodule
